// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - shared constants, keypad FSM states and key lookup for io_bridge
package io_bridge_pkg;

    localparam logic [1:0] ADDR_SW  = 2'd0;
    localparam logic [1:0] ADDR_KEY = 2'd1;
    localparam logic [1:0] ADDR_LED = 2'd2;

    localparam int KEY_VALID_BIT = 31;
    localparam int KEY_OVR_BIT   = 30;

    typedef enum logic [1:0] {
        KB_SCAN     = 2'd0,
        KB_PRESS_DB = 2'd1,
        KB_HELD     = 2'd2,
        KB_REL_DB   = 2'd3
    } kb_state_t;

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/io_bridge_debounce.sv
// rtl/io_bridge_debounce.sv - 2-flop synchroniser plus stable-count debouncer
module io_debounce #(
    parameter int W       = 1,
    parameter int DEB_CYC = 2
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    localparam int CNT_W = $clog2(DEB_CYC + 1);

    logic [W-1:0]     r_sync1;
    logic [W-1:0]     r_sync2;
    logic [W-1:0]     r_prev;
    logic [W-1:0]     r_out;
    logic [CNT_W-1:0] r_cnt;

    // r_prev lags r_sync2 by one cycle so any change restarts the stable count.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_out   <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_sync2 == r_out) begin
                r_cnt <= '0;
            end else if (r_sync2 != r_prev) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt >= CNT_W'(DEB_CYC - 1)) begin
                r_out <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign dout_o = r_out;

endmodule

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - memory-mapped switch, scanned keypad and LED peripheral
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int SW_W      = 24,
    parameter int LED_W     = 24,
    parameter int MODE_W    = 4,
    parameter int TEST_MODE = 2,
    parameter int SCAN_CYC  = 1000,
    parameter int DEB_CYC   = 20000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [SW_W-1:0]   switch_i,
    input  logic [3:0]        kb_col_i,
    output logic [3:0]        kb_row_o,
    output logic [LED_W-1:0]  led_o,
    input  logic [MODE_W-1:0] mode_i,
    input  logic [1:0]        io_addr_i,
    input  logic              io_rd_i,
    input  logic              io_wr_i,
    input  logic [31:0]       io_wdata_i,
    output logic [31:0]       io_rdata_o
);

    localparam int LO_W   = LED_W - MODE_W;
    localparam int SCAN_W = $clog2(SCAN_CYC + 1);
    localparam int DEB_W  = $clog2(DEB_CYC + 1);

    logic [SW_W-1:0] w_sw;

    io_debounce #(
        .W       (SW_W),
        .DEB_CYC (DEB_CYC)
    ) u_sw_deb (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .din_i   (switch_i),
        .dout_o  (w_sw)
    );

    logic [3:0]        r_col_s1;
    logic [3:0]        r_col_s2;
    logic [3:0]        w_col;
    logic              w_col_onehot;
    kb_state_t         r_state;
    kb_state_t         w_state_nxt;
    logic [3:0]        r_row;
    logic [3:0]        r_cap_col;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic              w_rotate;
    logic              w_capture;
    logic              w_deb_inc;
    logic              w_key_evt;
    logic              r_key_valid;
    logic              r_key_ovr;
    logic [3:0]        r_key_code;
    logic              w_rd_key;
    logic              w_test;
    logic              r_was_test;
    logic [LO_W-1:0]   r_led;
    logic [LO_W-1:0]   w_led_lo;
    logic              w_unused_wdata;

    assign w_col        = r_col_s2;
    assign w_col_onehot = (w_col != 4'b0) && ((w_col & (w_col - 4'd1)) == 4'b0);
    assign w_rd_key     = io_rd_i && (io_addr_i == ADDR_KEY);
    assign w_test       = (mode_i == MODE_W'(TEST_MODE));

    always_comb begin
        w_state_nxt = r_state;
        w_rotate    = 1'b0;
        w_capture   = 1'b0;
        w_deb_inc   = 1'b0;
        w_key_evt   = 1'b0;
        case (r_state)
            KB_SCAN: begin
                if (w_col_onehot) begin
                    w_capture   = 1'b1;
                    w_state_nxt = KB_PRESS_DB;
                end else if (r_scan_cnt == SCAN_W'(SCAN_CYC - 1)) begin
                    w_rotate = 1'b1;
                end
            end
            KB_PRESS_DB: begin
                if (w_col != r_cap_col) begin
                    w_state_nxt = KB_SCAN;
                end else if (r_deb_cnt == DEB_W'(DEB_CYC - 1)) begin
                    w_state_nxt = KB_HELD;
                    w_key_evt   = 1'b1;
                end else begin
                    w_deb_inc = 1'b1;
                end
            end
            KB_HELD: begin
                if (w_col == 4'b0) begin
                    w_state_nxt = KB_REL_DB;
                end
            end
            KB_REL_DB: begin
                if (w_col != 4'b0) begin
                    w_state_nxt = KB_HELD;
                end else if (r_deb_cnt == DEB_W'(DEB_CYC - 1)) begin
                    w_state_nxt = KB_SCAN;
                end else begin
                    w_deb_inc = 1'b1;
                end
            end
            default: w_state_nxt = KB_SCAN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= KB_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Row stays frozen outside SCAN, so rotation resumes from the captured row.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_col_s1   <= '0;
            r_col_s2   <= '0;
            r_row      <= 4'b0001;
            r_cap_col  <= '0;
            r_scan_cnt <= '0;
            r_deb_cnt  <= '0;
        end else begin
            r_col_s1  <= kb_col_i;
            r_col_s2  <= r_col_s1;
            r_deb_cnt <= w_deb_inc ? r_deb_cnt + 1'b1 : '0;
            if (r_state == KB_SCAN && !w_capture && !w_rotate) begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end else begin
                r_scan_cnt <= '0;
            end
            if (w_rotate) begin
                r_row <= {r_row[2:0], r_row[3]};
            end
            if (w_capture) begin
                r_cap_col <= w_col;
            end
        end
    end

    // A key event on the same edge as a key-register read wins and clears overrun.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_key_valid <= 1'b0;
            r_key_ovr   <= 1'b0;
            r_key_code  <= '0;
        end else if (w_key_evt) begin
            r_key_code  <= key_map(onehot_idx(r_row), onehot_idx(r_cap_col));
            r_key_valid <= 1'b1;
            r_key_ovr   <= w_rd_key ? 1'b0 : (r_key_ovr | r_key_valid);
        end else if (w_rd_key) begin
            r_key_valid <= 1'b0;
            r_key_ovr   <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_was_test <= 1'b0;
            r_led      <= '0;
        end else begin
            r_was_test <= w_test;
            if (r_was_test && !w_test) begin
                r_led <= '0;
            end else if (io_wr_i && io_addr_i == ADDR_LED && !w_test) begin
                r_led <= io_wdata_i[LO_W-1:0];
            end
        end
    end

    assign w_led_lo       = w_test ? {LO_W{1'b1}} : r_led;
    assign led_o          = {mode_i, w_led_lo};
    assign kb_row_o       = r_row;
    assign w_unused_wdata = ^io_wdata_i[31:LO_W];

    always_comb begin
        io_rdata_o = '0;
        case (io_addr_i)
            ADDR_SW:  io_rdata_o[SW_W-1:0] = w_sw;
            ADDR_KEY: begin
                io_rdata_o[KEY_VALID_BIT] = r_key_valid;
                io_rdata_o[KEY_OVR_BIT]   = r_key_ovr;
                io_rdata_o[3:0]           = r_key_code;
            end
            ADDR_LED: io_rdata_o[LO_W-1:0] = r_led;
            default:  io_rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_io_bridge.sv
// tb/tb_io_bridge.sv - scoreboard testbench for io_bridge
module tb_io_bridge;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic        clk_i;
    logic        rst_n_i;
    logic [23:0] switch_i;
    logic [3:0]  kb_col_i;
    logic [3:0]  kb_row_o;
    logic [23:0] led_o;
    logic [3:0]  mode_i;
    logic [1:0]  io_addr_i;
    logic        io_rd_i;
    logic        io_wr_i;
    logic [31:0] io_wdata_i;
    logic [31:0] io_rdata_o;

    logic        kp_en;
    logic [3:0]  kp_row;
    logic [3:0]  kp_cols;
    logic [1:0]  obs_kind;

    exp_t q_rd[$];
    exp_t q_obs[$];
    int   n_chk;
    int   n_fail;

    io_bridge #(
        .SW_W      (24),
        .LED_W     (24),
        .MODE_W    (4),
        .TEST_MODE (2),
        .SCAN_CYC  (3),
        .DEB_CYC   (4)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .switch_i   (switch_i),
        .kb_col_i   (kb_col_i),
        .kb_row_o   (kb_row_o),
        .led_o      (led_o),
        .mode_i     (mode_i),
        .io_addr_i  (io_addr_i),
        .io_rd_i    (io_rd_i),
        .io_wr_i    (io_wr_i),
        .io_wdata_i (io_wdata_i),
        .io_rdata_o (io_rdata_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Keypad: pressed columns are seen only while the pressed row is driven.
    always @* begin
        kb_col_i = (kp_en && ((kb_row_o & kp_row) != 4'b0)) ? kp_cols : 4'b0;
    end

    always @(negedge clk_i) begin
        exp_t e;
        logic [31:0] got;
        if (io_rd_i) begin
            n_chk++;
            if (q_rd.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got %h, expected no read", io_rdata_o);
            end else begin
                e = q_rd.pop_front();
                if (io_rdata_o !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", e.name, io_rdata_o, e.val);
                end
            end
        end
        if (obs_kind != 2'd0) begin
            got = (obs_kind == 2'd1) ? {8'h0, led_o} : {28'h0, kb_row_o};
            n_chk++;
            if (q_obs.size() == 0) begin
                n_fail++;
                $display("FAIL obs_unexpected: got %h, expected no probe", got);
            end else begin
                e = q_obs.pop_front();
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", e.name, got, e.val);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
        io_rd_i  = 1'b0;
        io_wr_i  = 1'b0;
        obs_kind = 2'd0;
    endtask

    task automatic do_read(input logic [1:0] addr, input logic [31:0] exp_v, input string name);
        exp_t e;
        e.name = name;
        e.val  = exp_v;
        q_rd.push_back(e);
        io_addr_i = addr;
        io_rd_i   = 1'b1;
        cyc();
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
        io_addr_i  = addr;
        io_wdata_i = data;
        io_wr_i    = 1'b1;
        cyc();
    endtask

    task automatic obs(input logic [1:0] kind, input logic [31:0] exp_v, input string name);
        exp_t e;
        e.name = name;
        e.val  = exp_v;
        q_obs.push_back(e);
        obs_kind = kind;
    endtask

    task automatic wait_row_entry(input logic [3:0] row, input string name);
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        prev  = kb_row_o;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (kb_row_o == row && prev != row) found = 1'b1;
            else prev = kb_row_o;
        end
        if (!found) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got timeout waiting for row, expected row %b", name, row);
        end
    endtask

    // Press aligned to the row's entry edge: the event lands 7 edges later.
    task automatic press(input int r, input int c, input bit rd_ev, input logic [31:0] exp_pre);
        kp_en   = 1'b0;
        kp_row  = 4'b0001 << r;
        kp_cols = 4'b0001 << c;
        wait_row_entry(kp_row, "press_sync");
        kp_en = 1'b1;
        repeat (6) cyc();
        if (rd_ev) do_read(2'd1, exp_pre, "key_same_edge_pre");
        else cyc();
        repeat (5) cyc();
        kp_en = 1'b0;
        repeat (12) cyc();
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst_n_i    = 1'b0;
        switch_i   = '0;
        mode_i     = '0;
        io_addr_i  = '0;
        io_rd_i    = 1'b0;
        io_wr_i    = 1'b0;
        io_wdata_i = '0;
        kp_en      = 1'b0;
        kp_row     = '0;
        kp_cols    = '0;
        obs_kind   = 2'd0;
        repeat (3) cyc();
        rst_n_i = 1'b1;

        obs(2'd1, 32'h0, "rst_led");
        cyc();
        obs(2'd2, 32'h1, "rst_row");
        do_read(2'd1, 32'h0, "rst_key");
        do_read(2'd0, 32'h0, "rst_sw");
        do_read(2'd2, 32'h0, "rst_led_rd");
        do_read(2'd3, 32'h0, "rst_addr3");

        switch_i = 24'h00A5A5;
        repeat (2) cyc();
        switch_i = 24'h0;
        for (int i = 0; i < 6; i++) do_read(2'd0, 32'h0, "sw_glitch");
        switch_i = 24'h00A5A5;
        for (int i = 0; i < 4; i++) do_read(2'd0, 32'h0, "sw_settling");
        repeat (3) cyc();
        do_read(2'd0, 32'h0000A5A5, "sw_stable");

        press(2, 1, 1'b0, 32'h0);
        do_read(2'd1, 32'h80000008, "key8_first");
        do_read(2'd1, 32'h00000008, "key8_cleared");

        press(1, 1, 1'b0, 32'h0);
        press(2, 2, 1'b0, 32'h0);
        do_read(2'd1, 32'hC0000009, "key59_ovr");
        do_read(2'd1, 32'h00000009, "key59_cleared");

        press(1, 1, 1'b0, 32'h0);
        press(2, 2, 1'b1, 32'h80000005);
        do_read(2'd1, 32'h80000009, "key_same_edge_post");

        kp_row  = 4'b0001;
        kp_cols = 4'b0110;
        kp_en   = 1'b1;
        wait_row_entry(4'b0001, "multi_sync");
        obs(2'd2, 32'h1, "multi_row0");
        repeat (3) cyc();
        obs(2'd2, 32'h2, "multi_row1");
        repeat (3) cyc();
        obs(2'd2, 32'h4, "multi_row2");
        repeat (3) cyc();
        obs(2'd2, 32'h8, "multi_row3");
        repeat (3) cyc();
        obs(2'd2, 32'h1, "multi_row0_again");
        cyc();
        kp_en = 1'b0;
        repeat (8) cyc();
        do_read(2'd1, 32'h00000009, "multi_no_event");

        mode_i = 4'd0;
        do_write(2'd2, 32'hFFF12345);
        obs(2'd1, 32'h00012345, "led_write");
        do_read(2'd2, 32'h00012345, "led_readback");
        do_write(2'd0, 32'h00000777);
        do_read(2'd2, 32'h00012345, "led_wr_other_addr");
        mode_i = 4'd2;
        obs(2'd1, 32'h002FFFFF, "led_test_mode");
        cyc();
        do_write(2'd2, 32'h00000001);
        obs(2'd1, 32'h002FFFFF, "led_test_write");
        do_read(2'd2, 32'h00012345, "led_test_discard");
        mode_i = 4'd3;
        cyc();
        obs(2'd1, 32'h00300000, "led_leave_test");
        do_read(2'd2, 32'h0, "led_leave_rd");

        kp_row  = 4'b0001;
        kp_cols = 4'b0001;
        kp_en   = 1'b0;
        wait_row_entry(4'b0001, "rst_mid_sync");
        kp_en = 1'b1;
        repeat (5) cyc();
        rst_n_i = 1'b0;
        repeat (2) cyc();
        rst_n_i = 1'b1;
        kp_en   = 1'b0;
        repeat (12) cyc();
        do_read(2'd1, 32'h0, "rst_mid_press");

        repeat (2) cyc();
        if (q_rd.size() != 0 || q_obs.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_rd.size() + q_obs.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
